// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - state encoding and shared constants for the PC fetch unit
package riscv_fetch_pkg;

  typedef logic [2:0] fetch_state_t;

  localparam fetch_state_t S_IDLE  = 3'd0;
  localparam fetch_state_t S_FETCH = 3'd1;
  localparam fetch_state_t S_HOLD  = 3'd2;
  localparam fetch_state_t S_DRAIN = 3'd3;
  localparam fetch_state_t S_TRAP  = 3'd4;

  localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_incrementer.sv
// rtl/pc_incrementer.sv - combinational PC+4, wraps modulo 2^WIDTH
module pc_incrementer #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc_i,
  output logic [WIDTH-1:0] pc_plus4_o
);

  assign pc_plus4_o = pc_i + WIDTH'(4);

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC register and req/ack instruction-fetch sequencer
// Optional misaligned-target trap: PC_MISALIGN_TRAP_EN.
module pc_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_InLow,
  input  logic [DATA_WIDTH-1:0] PC_NextPc_InBUS,
  input  logic                  PC_Redirect_In,
  input  logic                  PC_Stall_In,
  input  logic                  IMEM_Ack_In,
  input  logic [DATA_WIDTH-1:0] IMEM_Data_InBUS,
  output logic                  IMEM_Req_Out,
  output logic [DATA_WIDTH-1:0] IMEM_Addr_OutBUS,
  output logic [DATA_WIDTH-1:0] PC_Pc_OutBUS,
  output logic [DATA_WIDTH-1:0] PC_PcPlus4_OutBUS,
  output logic [DATA_WIDTH-1:0] PC_Instr_OutBUS,
  output logic                  PC_Valid_Out,
  output logic                  PC_Misaligned_Out
);

  fetch_state_t          state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] redir_q, redir_d;
  logic                  valid_q, valid_d;
  logic                  req_q, req_d;
  logic                  load_en;
  logic [DATA_WIDTH-1:0] load_val;
`ifdef PC_MISALIGN_TRAP_EN
  logic                  mis_q, mis_d;
`endif

  pc_incrementer #(.WIDTH(DATA_WIDTH)) u_pc_incrementer (
    .pc_i       (pc_q),
    .pc_plus4_o (PC_PcPlus4_OutBUS)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    redir_d  = redir_q;
    valid_d  = valid_q;
    load_en  = 1'b0;
    load_val = PC_NextPc_InBUS;
`ifdef PC_MISALIGN_TRAP_EN
    mis_d    = mis_q;
`endif

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        if (PC_Redirect_In) begin
          valid_d = 1'b0;
          if (IMEM_Ack_In) begin
            load_en = 1'b1;
          end else begin
            redir_d = PC_NextPc_InBUS;
            state_d = S_DRAIN;
          end
        end else if (IMEM_Ack_In) begin
          instr_d  = IMEM_Data_InBUS;
          valid_d  = 1'b1;
          pc_out_d = pc_q;
          if (PC_Stall_In) state_d = S_HOLD;
          else             load_en = 1'b1;
        end else begin
          valid_d = valid_q & PC_Stall_In;
        end
      end

      S_HOLD: begin
        if (PC_Redirect_In || !PC_Stall_In) begin
          valid_d = 1'b0;
          load_en = 1'b1;
        end
      end

      // The request already issued must complete; its data is thrown away.
      S_DRAIN: begin
        if (IMEM_Ack_In) begin
          load_en  = 1'b1;
          load_val = PC_Redirect_In ? PC_NextPc_InBUS : redir_q;
        end else if (PC_Redirect_In) begin
          redir_d = PC_NextPc_InBUS;
        end
      end

`ifdef PC_MISALIGN_TRAP_EN
      S_TRAP: ;
`endif

      default: state_d = S_IDLE;
    endcase

    if (load_en) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (load_val[1:0] != 2'b00) begin
        state_d = S_TRAP;
        mis_d   = 1'b1;
        valid_d = 1'b0;
      end else begin
        pc_d    = load_val;
        state_d = S_FETCH;
      end
`else
      pc_d    = load_val & ~DATA_WIDTH'(3);
      state_d = S_FETCH;
`endif
    end
  end

  // Request is registered from the next state so it never depends combinationally on inputs.
  assign req_d = (state_d == S_FETCH) || (state_d == S_DRAIN);

  always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
    if (!RESET_InLow) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_VECTOR;
      pc_out_q <= RESET_VECTOR;
      instr_q  <= DATA_WIDTH'(NOP_INSTR);
      redir_q  <= '0;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      redir_q  <= redir_d;
      valid_q  <= valid_d;
      req_q    <= req_d;
`ifdef PC_MISALIGN_TRAP_EN
      mis_q    <= mis_d;
`endif
    end
  end

  assign IMEM_Req_Out     = req_q;
  assign IMEM_Addr_OutBUS = pc_q;
  assign PC_Pc_OutBUS     = pc_out_q;
  assign PC_Instr_OutBUS  = instr_q;
  assign PC_Valid_Out     = valid_q;
`ifdef PC_MISALIGN_TRAP_EN
  assign PC_Misaligned_Out = mis_q;
`else
  assign PC_Misaligned_Out = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and randomized bench for pc_fetch_unit against a behavioural model
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] next_pc = '0;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        req;
  logic [31:0] addr, pc_out, pc_plus4, instr;
  logic        valid, misaligned;

  int n_cmp = 0;
  int n_bad = 0;

  pc_fetch_unit #(.DATA_WIDTH(32), .RESET_VECTOR(32'h0)) dut (
    .CLOCK_50          (clk),
    .RESET_InLow       (rst_n),
    .PC_NextPc_InBUS   (next_pc),
    .PC_Redirect_In    (redirect),
    .PC_Stall_In       (stall),
    .IMEM_Ack_In       (ack),
    .IMEM_Data_InBUS   (imem_data),
    .IMEM_Req_Out      (req),
    .IMEM_Addr_OutBUS  (addr),
    .PC_Pc_OutBUS      (pc_out),
    .PC_PcPlus4_OutBUS (pc_plus4),
    .PC_Instr_OutBUS   (instr),
    .PC_Valid_Out      (valid),
    .PC_Misaligned_Out (misaligned)
  );

  always #5 clk = ~clk;

  // Behavioural model: flags describing what the fetcher is doing, not a state register.
  logic [31:0] m_pc, m_ipc, m_instr, m_target;
  logic        m_valid, m_started, m_holding, m_draining, m_trapped, m_mis;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_ipc = 32'h0; m_instr = 32'h0000_0013; m_target = 32'h0;
    m_valid = 0; m_started = 0; m_holding = 0; m_draining = 0; m_trapped = 0; m_mis = 0;
  endtask

  task automatic model_load(input logic [31:0] v);
`ifdef PC_MISALIGN_TRAP_EN
    if (v[1:0] != 2'b00) begin
      m_trapped = 1; m_mis = 1; m_valid = 0;
      return;
    end
`endif
    m_pc = v & 32'hFFFF_FFFC;
  endtask

  task automatic model_step(input logic r, input logic s, input logic a,
                            input logic [31:0] d, input logic [31:0] n);
    logic consumed;
    consumed = m_valid && !s;
    if (m_trapped) begin
    end else if (!m_started) begin
      m_started = 1;
    end else if (m_draining) begin
      if (r) m_target = n;
      if (a) begin m_draining = 0; model_load(m_target); end
    end else if (m_holding) begin
      if (r || !s) begin m_holding = 0; m_valid = 0; model_load(n); end
    end else if (r) begin
      m_valid = 0;
      if (a) model_load(n);
      else begin m_target = n; m_draining = 1; end
    end else if (a) begin
      m_instr = d; m_valid = 1; m_ipc = m_pc;
      if (s) m_holding = 1;
      else   model_load(n);
    end else if (consumed) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all();
    check_eq("req",      {31'b0, req},        {31'b0, m_started && !m_trapped && !m_holding});
    check_eq("addr",     addr,                m_pc);
    check_eq("pcplus4",  pc_plus4,            m_pc + 32'd4);
    check_eq("valid",    {31'b0, valid},      {31'b0, m_valid});
    check_eq("instr",    instr,               m_instr);
    check_eq("pc_out",   pc_out,              m_ipc);
    check_eq("misalign", {31'b0, misaligned}, {31'b0, m_mis});
  endtask

  // Called just after a falling edge: drive, advance one rising edge, check on the next falling edge.
  task automatic step(input logic r, input logic s, input logic a,
                      input logic [31:0] d, input logic [31:0] n);
    redirect = r; stall = s; ack = a; imem_data = d; next_pc = n;
    model_step(r, s, a, d, n);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("rst_instr_nop", instr, 32'h0000_0013);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // Ack tied high: S_IDLE for one cycle, then one instruction per cycle.
    step(0, 0, 1, 32'hAAAA_0000, 32'h4);
    check_eq("req_1cyc_after_reset", {31'b0, req}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 32'h1000 + i, m_pc + 32'd4);
      check_eq("seq_pc",    pc_out, 32'(i * 4));
      check_eq("seq_valid", {31'b0, valid}, 32'd1);
      check_eq("seq_instr", instr, 32'h1000 + i);
    end
    step(0, 0, 1, 32'h2000, 32'h10);

    // Delayed ack at 0x10, captured under stall: request stays put, then hold.
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 32'h0, 32'h14);
      check_eq("wait_addr", addr, 32'h10);
      check_eq("wait_req",  {31'b0, req}, 32'd1);
    end
    step(0, 1, 1, 32'hDEAD_BEEF, 32'h14);
    check_eq("ack_instr", instr, 32'hDEAD_BEEF);
    check_eq("hold_req",  {31'b0, req}, 32'd0);
    step(0, 1, 0, 32'h0, 32'h14);
    check_eq("hold_pc",    pc_out, 32'h10);
    check_eq("hold_valid", {31'b0, valid}, 32'd1);
    step(0, 0, 0, 32'h0, 32'h14);
    check_eq("resume_addr", addr, 32'h14);

    // Redirect while the fetch at 0x14 is outstanding; ack arrives two cycles later.
    step(1, 0, 0, 32'h0, 32'h100);
    check_eq("drain_addr", addr, 32'h14);
    step(0, 0, 0, 32'h0, 32'h18);
    step(0, 0, 1, 32'hBAD0_BAD0, 32'h18);
    check_eq("redir_addr",  addr, 32'h100);
    check_eq("redir_valid", {31'b0, valid}, 32'd0);

    // PC+4 wraps at the top of the address space.
    step(1, 0, 1, 32'h0, 32'hFFFF_FFFC);
    check_eq("wrap_plus4", pc_plus4, 32'h0);

    // Misaligned target.
    step(1, 0, 1, 32'h0, 32'h102);
`ifdef PC_MISALIGN_TRAP_EN
    check_eq("trap_flag", {31'b0, misaligned}, 32'd1);
    step(0, 0, 1, 32'h0, 32'h200);
    check_eq("trap_req",  {31'b0, req}, 32'd0);
`else
    check_eq("align_addr", addr, 32'h100);
`endif

    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        logic [31:0] n;
        n = ($urandom_range(0, 9) < 7) ? m_pc + 32'd4
          : (($urandom_range(0, 39) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC));
        step($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 25,
             $urandom_range(0, 1) == 1, $urandom, n);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
